// File: rtl/fb_ex_mem_reg.sv
// +--------------------------------------------------------------------------+
// | fb_ex_mem_reg : EX/MEM pipeline register with flag register and branch   |
// | redirect. Optional perf counters when FB_EXMEM_PERF_EN is defined.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fb_ex_mem_reg #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_res,
  input  logic [3:0]      ex_csr,
  input  logic            ex_csr_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_br_target,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            stall,
  input  logic            flush,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_res,
  output logic [XLEN-1:0] mem_pc,
  output logic [RD_W-1:0] mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic [XLEN-1:0] mem_store_data,
  output logic [3:0]      flags,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef FB_EXMEM_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_taken_cnt
`endif
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] alu_res_q, alu_res_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [3:0]      flags_q, flags_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            accept;
  logic            br_taken;

  // Flag layout is {NF,ZF,CF,VF}; conditions evaluate the incoming ALU flags.
  always_comb begin
    br_taken = 1'b0;
    case (ex_funct3)
      3'b000:  br_taken = ex_csr[2];
      3'b001:  br_taken = ~ex_csr[2];
      3'b100:  br_taken = ex_csr[3] ^ ex_csr[0];
      3'b101:  br_taken = ~(ex_csr[3] ^ ex_csr[0]);
      3'b110:  br_taken = ~ex_csr[1];
      3'b111:  br_taken = ex_csr[1];
      default: br_taken = 1'b0;
    endcase
  end

  assign accept = ex_valid & ~stall & ~flush;

  always_comb begin
    valid_d          = valid_q;
    alu_res_d        = alu_res_q;
    pc_d             = pc_q;
    rd_d             = rd_q;
    reg_write_d      = reg_write_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    store_data_d     = store_data_q;
    flags_d          = flags_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!stall) begin
      valid_d      = ex_valid;
      alu_res_d    = ex_alu_res;
      pc_d         = ex_pc;
      rd_d         = ex_rd;
      store_data_d = ex_store_data;
      reg_write_d  = ex_reg_write & ex_valid;
      mem_read_d   = ex_mem_read & ex_valid;
      mem_write_d  = ex_mem_write & ex_valid;
      if (accept && ex_csr_write) begin
        flags_d = ex_csr;
        if (br_taken) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = ex_br_target;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= 1'b0;
      alu_res_q        <= '0;
      pc_q             <= '0;
      rd_q             <= '0;
      reg_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      store_data_q     <= '0;
      flags_q          <= 4'b0000;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      valid_q          <= valid_d;
      alu_res_q        <= alu_res_d;
      pc_q             <= pc_d;
      rd_q             <= rd_d;
      reg_write_q      <= reg_write_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      store_data_q     <= store_data_d;
      flags_q          <= flags_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_alu_res    = alu_res_q;
  assign mem_pc         = pc_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_store_data = store_data_q;
  assign flags          = flags_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef FB_EXMEM_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  // Both counters wrap naturally at 32 bits.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, (stall & ~flush)};
    taken_cnt_d = taken_cnt_q + {31'd0, redirect_valid_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_taken_cnt = taken_cnt_q;
`endif

endmodule

`default_nettype wire
